// File: rtl/varint_pkg.sv
// Types and sizing helper shared by the varint gather and decode stages.
package varint_pkg;

  // Bytes needed to carry a decode_size-bit value as 7-bit groups.
  function automatic int unsigned varint_enc_bytes(input int unsigned decode_size);
    return (decode_size - 1) / 7 + 1;
  endfunction

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DISCARD = 2'd2
  } varint_gather_state_e;

  typedef logic [3:0] varint_len_t;

endpackage

// File: rtl/varint_byte_gatherer.sv
// Gathers one protobuf varint (bytes through the first with bit7 == 0) into an MSB-aligned window.
// Optional overlong-varint error/discard behaviour is enabled by defining VARINT_GATHER_ERR_EN.
module varint_byte_gatherer
  import varint_pkg::*;
#(
  parameter int unsigned DECODE_SIZE = 64,
  parameter int unsigned ENCODE_SIZE = varint_enc_bytes(DECODE_SIZE) * 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ENCODE_SIZE-1:0] out_data,
  output varint_len_t            out_len,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned NB      = ENCODE_SIZE / 8;
  localparam varint_len_t LastIdx = varint_len_t'(NB - 1);

`ifdef VARINT_GATHER_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  varint_gather_state_e   state_q, state_d;
  logic [ENCODE_SIZE-1:0] data_q, data_d;
  varint_len_t            idx_q, idx_d;
  varint_len_t            len_q, len_d;
  logic                   err_q, err_d;
  logic                   discard_q, discard_d;

  logic                   accept;
  logic                   gather;
  logic                   drop_term;
  logic                   term;
  logic                   overlong;
  varint_len_t            wr_idx;
  logic [ENCODE_SIZE-1:0] wr_data;

  assign accept    = in_valid & in_ready;
  assign drop_term = accept & ~in_data[7];
  // A byte joins a window unless it belongs to the tail of an overlong varint.
  assign gather    = accept & ((state_q == COLLECT) | ((state_q == FULL) & ~discard_q));
  // Out of FULL the incoming byte always opens a fresh window at slot 0.
  assign wr_idx    = (state_q == FULL) ? '0 : idx_q;
  assign term      = ~in_data[7] | (wr_idx == LastIdx);
  assign overlong  = ErrEn & in_data[7];

  // Keep slots before wr_idx, place the byte at wr_idx, zero everything after.
  always_comb begin
    wr_data = '0;
    for (int k = 0; k < NB; k++) begin
      if (varint_len_t'(k) < wr_idx) begin
        wr_data[8*(NB-1-k) +: 8] = data_q[8*(NB-1-k) +: 8];
      end else if (varint_len_t'(k) == wr_idx) begin
        wr_data[8*(NB-1-k) +: 8] = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      data_q    <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      err_q     <= err_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    len_d     = len_q;
    err_d     = err_q;
    discard_d = discard_q;

    if ((state_q == FULL) && out_ready) begin
      data_d    = '0;
      len_d     = '0;
      err_d     = 1'b0;
      idx_d     = '0;
      discard_d = 1'b0;
      state_d   = (discard_q && !drop_term) ? DISCARD : COLLECT;
    end else if ((state_q == FULL) && discard_q && drop_term) begin
      // Overlong tail ended while its error window is still waiting.
      discard_d = 1'b0;
    end

    if ((state_q == DISCARD) && drop_term) begin
      state_d = COLLECT;
    end

    if (gather) begin
      data_d = wr_data;
      if (term) begin
        state_d   = FULL;
        len_d     = wr_idx + 4'd1;
        idx_d     = '0;
        err_d     = overlong;
        discard_d = overlong;
      end else begin
        state_d = COLLECT;
        idx_d   = wr_idx + 4'd1;
      end
    end
  end

  always_comb begin
    in_ready = ~rst & ((state_q == COLLECT) | (state_q == DISCARD) |
                       ((state_q == FULL) & (out_ready | discard_q)));
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_len   = len_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_varint_byte_gatherer.sv
// Scoreboard bench for varint_byte_gatherer: directed cases plus random byte streams.
module tb_varint_byte_gatherer;
  import varint_pkg::*;

  localparam int NB = 10;
  localparam int EW = NB * 8;

`ifdef VARINT_GATHER_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] out_data;
  varint_len_t   out_len;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;

  varint_byte_gatherer #(
    .DECODE_SIZE(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_len  (out_len),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [EW-1:0] data;
    logic [3:0]    len;
    logic          err;
  } win_t;

  win_t            exp_q[$];
  win_t            seen[$];
  logic [7:0]      cur[$];
  bit              discarding = 1'b0;
  int              checks = 0;
  int              failures = 0;
  bit              checking = 1'b0;
  bit              rdy_rand = 1'b0;
  bit              rst_prev = 1'b0;
  bit              stall_prev = 1'b0;
  logic [EW+4:0]   prev_out;

  function automatic void chk(input string name, input logic [127:0] got,
                              input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference: varint framing by plain list operations on accepted bytes.
  function automatic void model_byte(input logic [7:0] b);
    win_t w;
    if (discarding) begin
      if (!b[7]) discarding = 1'b0;
      return;
    end
    cur.push_back(b);
    if (!b[7] || cur.size() == NB) begin
      w.data = '0;
      for (int k = 0; k < cur.size(); k++) w.data[8*(NB-1-k) +: 8] = cur[k];
      w.len = 4'(cur.size());
      w.err = ErrEn && b[7];
      discarding = w.err;
      exp_q.push_back(w);
      cur.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      if (rst) begin
        chk("in_ready_in_reset", in_ready, 0);
        if (rst_prev) chk("out_valid_in_reset", out_valid, 0);
        exp_q.delete();
        cur.delete();
        discarding = 1'b0;
        stall_prev = 1'b0;
      end else begin
        chk("valid_vs_pending", out_valid, exp_q.size() != 0);
        chk("in_ready", in_ready, !out_valid || out_ready || discarding);
        if (out_valid && stall_prev) chk("stall_hold", {out_data, out_len, out_err}, prev_out);
        if (out_valid && out_ready) begin
          seen.push_back({out_data, out_len, out_err});
          if (exp_q.size() != 0) begin
            win_t w;
            w = exp_q.pop_front();
            chk("out_data", out_data, w.data);
            chk("out_len", out_len, w.len);
            chk("out_err", out_err, w.err);
          end
        end
        if (in_valid && in_ready) model_byte(in_data);
        stall_prev = out_valid && !out_ready;
        prev_out   = {out_data, out_len, out_err};
      end
      rst_prev = rst;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed %0b for byte %0h", in_ready, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  function automatic void exp_win(input string name, input int i, input logic [EW-1:0] d,
                                  input logic [3:0] l, input logic e);
    chk({name, "_count"}, seen.size() > i, 1);
    if (seen.size() > i) begin
      chk({name, "_data"}, seen[i].data, d);
      chk({name, "_len"}, seen[i].len, l);
      chk({name, "_err"}, seen[i].err, e);
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    idle(2);
    checking = 1'b1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_len", out_len, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    idle(1);

    // 1: two-byte varint
    seen.delete();
    out_ready = 1'b1;
    send(8'h96);
    send(8'h01);
    drain();
    exp_win("t1", 0, 80'h9601_0000_0000_0000_0000, 4'd2, 1'b0);

    // 2: back-to-back single-byte varints
    seen.delete();
    send(8'h05);
    send(8'h7F);
    drain();
    exp_win("t2a", 0, 80'h05 << 72, 4'd1, 1'b0);
    exp_win("t2b", 1, 80'h7F << 72, 4'd1, 1'b0);

    // 3: stalled output, then release together with a new byte
    seen.delete();
    out_ready = 1'b0;
    send(8'hAC);
    send(8'h02);
    idle(5);
    chk("t3_stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    send(8'h08);
    drain();
    exp_win("t3a", 0, 80'hAC02 << 64, 4'd2, 1'b0);
    exp_win("t3b", 1, 80'h08 << 72, 4'd1, 1'b0);

    // 4: maximum-length varint
    seen.delete();
    repeat (9) send(8'hFF);
    send(8'h01);
    drain();
    exp_win("t4", 0, 80'hFFFF_FFFF_FFFF_FFFF_FF01, 4'd10, 1'b0);

    // 5: overlong varint
    seen.delete();
    repeat (11) send(8'hFF);
    send(8'h00);
    send(8'h03);
    drain();
`ifdef VARINT_GATHER_ERR_EN
    exp_win("t5a", 0, {10{8'hFF}}, 4'd10, 1'b1);
    exp_win("t5b", 1, 80'h03 << 72, 4'd1, 1'b0);
    chk("t5_count", seen.size(), 2);
`else
    exp_win("t5a", 0, {10{8'hFF}}, 4'd10, 1'b0);
    exp_win("t5b", 1, 80'hFF00 << 64, 4'd2, 1'b0);
    exp_win("t5c", 2, 80'h03 << 72, 4'd1, 1'b0);
    chk("t5_count", seen.size(), 3);
`endif

    // 6: reset in the middle of a varint
    seen.delete();
    send(8'h81);
    send(8'h82);
    send(8'h83);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    send(8'h2A);
    drain();
    chk("t6_count", seen.size(), 1);
    exp_win("t6", 0, 80'h2A << 72, 4'd1, 1'b0);

    // Random streams with random backpressure, gaps, long runs and one reset
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(9, 12)) send(8'hFF);
      end
      b = 8'($urandom);
      b[7] = ($urandom_range(0, 9) < 7);
      send(b);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      if (i == 200) begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end
    end
    rdy_rand = 1'b0;
    send(8'h00);
    drain();
    idle(2);
    chk("end_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
